// File: rtl/cp0_unit.sv
// Coprocessor-0 for the five-stage MIPS pipeline: SR/Cause/EPC/PRId, exception and
// interrupt entry from the memory stage, mtc0/mfc0 access and the eret return address.
module cp0_unit #(
    parameter logic [31:0] PRID_VAL = 32'h0000_2023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        eret_in,
    output logic        int_req,
    output logic [31:0] epc_out
);
    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_irq;
    logic        w_exc;
    logic [29:0] w_vpc_word;
    logic [31:0] w_epc_entry;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_unused;

    assign w_irq   = r_ie & (|(hw_int & r_im));
    assign w_exc   = |exc_code_in;
    assign int_req = ~r_exl & (w_irq | w_exc);

    // A delay-slot fault returns to the branch, one word earlier.
    assign w_vpc_word  = bd_in ? (vpc[31:2] - 30'd1) : vpc[31:2];
    assign w_epc_entry = {w_vpc_word, 2'b00};
    assign w_unused    = &{1'b0, vpc[1:0]};

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b00};

    always_comb begin
        cp0_out = 32'b0;
        case (cp0_addr)
            5'd12:   cp0_out = w_sr;
            5'd13:   cp0_out = w_cause;
            5'd14:   cp0_out = r_epc;
            5'd15:   cp0_out = PRID_VAL;
            default: cp0_out = 32'b0;
        endcase
    end

    // A squashed mtc0 (int_req high) must not leak its data onto the eret path.
    assign epc_out = (we && (cp0_addr == 5'd14) && !int_req) ? {cp0_in[31:2], 2'b00} : r_epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im       <= 6'b0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'b0;
            r_exc_code <= 5'b0;
            r_epc      <= 32'b0;
        end else begin
            r_ip <= hw_int;
            if (int_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bd_in;
                r_exc_code <= w_irq ? 5'd0 : exc_code_in;
                r_epc      <= w_epc_entry;
            end else if (eret_in) begin
                r_exl <= 1'b0;
            end else if (we) begin
                case (cp0_addr)
                    5'd12: begin
                        r_im  <= cp0_in[15:10];
                        r_exl <= cp0_in[1];
                        r_ie  <= cp0_in[0];
                    end
                    5'd14:   r_epc <= {cp0_in[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: stimulus queues expected outputs per cycle and a
// negedge monitor pops and compares them against the live DUT outputs.
module tb_cp0_unit;
    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        eret_in;
    logic        int_req;
    logic [31:0] epc_out;

    cp0_unit #(.PRID_VAL(32'h0000_2023)) dut (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .eret_in(eret_in), .int_req(int_req), .epc_out(epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 cp0_out, 1 int_req, 2 epc_out
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    logic done;

    task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [31:0] act, input logic [31:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; cp0_in = 32'b0; bd_in = 1'b0; exc_code_in = 5'd0; eret_in = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp, input string name);
        idle();
        cp0_addr = addr;
        expect_out(0, exp, name);
        tick();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        idle();
        we = 1'b1; cp0_addr = addr; cp0_in = data;
    endtask

    always @(negedge clk) begin
        logic [31:0] act;
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            case (e.kind)
                0:       act = cp0_out;
                1:       act = {31'b0, int_req};
                default: act = epc_out;
            endcase
            checks++;
            if (act !== e.exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
            end
        end
        if (done) begin
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #20000;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL watchdog: bench did not complete in time");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        checks = 0; failures = 0; done = 1'b0;
        reset = 1'b0; cp0_addr = 5'd0; vpc = 32'b0; hw_int = 6'b0;
        idle();
        #1;
        check_now({31'b0, int_req}, 32'd0, "rst_now_int_req");
        check_now(epc_out, 32'h0, "rst_now_epc_out");
        tick();
        // reset state
        expect_out(1, 32'd0, "rst_int_req");
        rd(5'd12, 32'h0, "rst_sr");
        rd(5'd13, 32'h0, "rst_cause");
        expect_out(2, 32'h0, "rst_epc_out");
        rd(5'd14, 32'h0, "rst_epc");
        rd(5'd15, 32'h0000_2023, "prid");
        reset = 1'b1;
        tick();

        // SR write / read-back, then clear EXL
        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_out(1, 32'd0, "sr_wr_int_req");
        tick();
        rd(5'd12, 32'h0000_FC03, "sr_readback");
        mtc0(5'd12, 32'h0);
        tick();
        rd(5'd12, 32'h0, "sr_cleared");

        // exception, not in a delay slot
        idle(); exc_code_in = 5'd4; vpc = 32'h3008;
        expect_out(1, 32'd1, "exc_int_req");
        tick();
        expect_out(2, 32'h3008, "exc_epc_out");
        rd(5'd14, 32'h3008, "exc_epc");
        rd(5'd13, 32'h0000_0010, "exc_cause");
        idle(); cp0_addr = 5'd12; exc_code_in = 5'd5;
        expect_out(0, 32'h2, "exc_sr_exl");
        expect_out(1, 32'd0, "exl_blocks_exc");
        tick();
        idle(); eret_in = 1'b1;
        tick();
        rd(5'd12, 32'h0, "eret_clears_exl");

        // exception in a delay slot
        idle(); exc_code_in = 5'd10; bd_in = 1'b1; vpc = 32'h3010;
        expect_out(1, 32'd1, "bd_int_req");
        tick();
        rd(5'd14, 32'h300C, "bd_epc");
        rd(5'd13, 32'h8000_0028, "bd_cause");
        idle(); eret_in = 1'b1;
        tick();

        // interrupt beats exception
        mtc0(5'd12, 32'h0000_0401);
        tick();
        idle(); hw_int = 6'b000001; exc_code_in = 5'd12; vpc = 32'h4000;
        expect_out(1, 32'd1, "irq_int_req");
        tick();
        hw_int = 6'b0;
        rd(5'd13, 32'h0000_0400, "irq_cause_code0");
        rd(5'd14, 32'h4000, "irq_epc");
        idle(); eret_in = 1'b1;
        tick();

        // masking: wrong line, then IE=0
        idle(); hw_int = 6'b000010;
        expect_out(1, 32'd0, "mask_im_int_req");
        tick();
        expect_out(1, 32'd0, "mask_im_int_req2");
        rd(5'd13, 32'h0000_0800, "mask_ip_tracks");
        mtc0(5'd12, 32'h0000_0400);
        tick();
        idle(); hw_int = 6'b000001;
        expect_out(1, 32'd0, "mask_ie_int_req");
        tick();
        rd(5'd13, 32'h0000_0400, "mask_ie_ip");

        // write squash during entry
        hw_int = 6'b0;
        mtc0(5'd12, 32'h0000_0401);
        tick();
        mtc0(5'd14, 32'h0000_1234); exc_code_in = 5'd4; vpc = 32'h5000;
        expect_out(1, 32'd1, "squash_int_req");
        expect_out(2, 32'h4000, "squash_no_bypass");
        tick();
        rd(5'd14, 32'h5000, "squash_epc");

        // bypass while EXL=1
        mtc0(5'd14, 32'h0000_3021);
        expect_out(2, 32'h3020, "bypass_epc_out");
        expect_out(1, 32'd0, "bypass_int_req");
        tick();
        rd(5'd14, 32'h3020, "bypass_epc_stored");

        // eret with pending interrupt: int_req in the next cycle
        idle(); eret_in = 1'b1; hw_int = 6'b000001;
        expect_out(1, 32'd0, "eret_cycle_int_req");
        tick();
        idle(); cp0_addr = 5'd12; vpc = 32'h6000;
        expect_out(0, 32'h0000_0401, "after_eret_sr");
        expect_out(1, 32'd1, "after_eret_int_req");
        tick();
        idle(); cp0_addr = 5'd12;
        expect_out(0, 32'h0000_0403, "reentry_sr");
        expect_out(1, 32'd0, "reentry_int_req");
        tick();

        // asynchronous reset with EXL=1, asserted mid-cycle
        idle(); cp0_addr = 5'd12;
        #1 reset = 1'b0;
        #1;
        check_now(cp0_out, 32'h0, "async_rst_now_sr");
        check_now({31'b0, int_req}, 32'd0, "async_rst_now_int_req");
        expect_out(0, 32'h0, "async_rst_sr");
        expect_out(1, 32'd0, "async_rst_int_req");
        tick();
        rd(5'd14, 32'h0, "async_rst_epc");
        rd(5'd13, 32'h0, "async_rst_cause");
        reset = 1'b1;
        done = 1'b1;
    end
endmodule
